// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared constants for the bit-serial adder stage.
//   ST_IDLE / ST_SHIFT : FSM state codes (2'd2 and 2'd3 are unused codes that
//                        the controller treats exactly like ST_IDLE)
//   DEFAULT_WIDTH      : default operand / sum width
//   cnt_width()        : bit-counter width for a given operand width; one bit
//                        wider than strictly needed so the counter can reach
//                        WIDTH without wrapping
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// ---------------------------------------------------------------------------
// full_adder_cell
// Combinational one-bit full adder made from two half-adder cells and an OR.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// ---------------------------------------------------------------------------
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder_cell u_ha_ab (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  // The second stage only generates a carry when a^b propagates cin, so the
  // two partial carries are never both high and a plain OR merges them.
  half_adder_cell u_ha_cin (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder_cell.sv
// ---------------------------------------------------------------------------
// half_adder_cell
// One-bit half adder, the basic cell the serial adder is built from.
// Ports:
//   a, b  : input bits
//   s     : sum bit   (a ^ b)
//   c     : carry bit (a & b)
// ---------------------------------------------------------------------------
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: captures two WIDTH-bit operands on start_in, streams them
// LSB first through a single full-adder cell with a registered carry, and
// presents the parallel sum with a one-cycle done pulse.
//
// Optional build macro: SERIAL_ADDER_SUB_EN
//   When defined, adds the sub_in port. sub_in=1 (sampled with start_in)
//   computes a_in - b_in mod 2^WIDTH; carry_out=1 then means "no borrow".
//
// Ports:
//   clk_in             : rising-edge clock
//   rst_in             : asynchronous active-high reset
//   start_in           : start strobe, ignored while busy
//   a_in, b_in         : operands, captured with start_in
//   sub_in             : subtract select (SERIAL_ADDER_SUB_EN builds only)
//   busy_out           : high while bits are being processed
//   done_out           : one-cycle pulse, sum_out/carry_out valid
//   sum_out            : parallel sum, held until the next done
//   carry_out          : final carry, held with sum_out
//   sum_bit_out        : serial sum bit, LSB first
//   sum_bit_valid_out  : qualifies sum_bit_out
// ---------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             sum_bit_out,
  output logic             sum_bit_valid_out
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             carry;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] load_b;
  logic             load_carry;

  // Operand B and the starting carry: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    load_b     = sub_in ? ~b_in : b_in;
    load_carry = sub_in;
  end
`else
  always_comb begin
    load_b     = b_in;
    load_carry = 1'b0;
  end
`endif

  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Each new sum bit enters at the MSB; after WIDTH steps the first bit has
  // walked down to bit 0. Only the upper WIDTH-1 bits need storing because
  // the newest bit comes straight from the adder.
  assign res_next = {fa_s, res_sr};

  assign busy_out = (state == ST_SHIFT);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= ST_IDLE;
      count             <= '0;
      a_sr              <= '0;
      b_sr              <= '0;
      res_sr            <= '0;
      carry             <= 1'b0;
      done_out          <= 1'b0;
      sum_out           <= '0;
      carry_out         <= 1'b0;
      sum_bit_out       <= 1'b0;
      sum_bit_valid_out <= 1'b0;
    end else begin
      done_out          <= 1'b0;
      sum_bit_valid_out <= 1'b0;
      case (state)
        ST_SHIFT: begin
          a_sr              <= a_sr >> 1;
          b_sr              <= b_sr >> 1;
          res_sr            <= res_next[WIDTH-1:1];
          carry             <= fa_c;
          sum_bit_out       <= fa_s;
          sum_bit_valid_out <= 1'b1;
          count             <= count + 1'b1;
          if (count == LAST_BIT) begin
            sum_out   <= res_next;
            carry_out <= fa_c;
            done_out  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        // ST_IDLE and the two unused codes all behave as idle.
        default: begin
          state <= ST_IDLE;
          if (start_in) begin
            a_sr  <= a_in;
            b_sr  <= load_b;
            carry <= load_carry;
            count <= '0;
            state <= ST_SHIFT;
          end
        end
      endcase
    end
  end

endmodule
